// File: rtl/master.sv
// Transmitter side of the valid/ready handshake: a DEPTH-entry FIFO feeding a
// registered output stage that holds each word until the receiver accepts it.
module master #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           mdata_in,
    input  logic                       valid_en,
    input  logic                       ready,
    output logic                       valid,
    output logic [WIDTH-1:0]           mdata_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           tx_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;
    state_t           state_reg;
    logic             valid_reg;
    logic [WIDTH-1:0] mdata_reg;
    logic [CNT_W-1:0] tx_count_reg;

    logic push;
    logic launch;
    logic done;

    assign full  = (level_reg == LVL_W'(DEPTH));
    assign empty = (level_reg == '0);

    // full is judged on the current level, so a pop in the same cycle never
    // opens room for a write into a full FIFO.
    assign push   = wr_en && !full;
    assign launch = valid_en && !empty && ((state_reg == IDLE) || ready);
    assign done   = valid_reg && ready;

    always_comb begin
        level_next = level_reg;
        case ({push, launch})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // Storage array left unreset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= mdata_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (launch) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
        end
    end

    // Output stage: the head is read straight into the registered data output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            mdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        state_reg <= SEND;
                        valid_reg <= 1'b1;
                        mdata_reg <= mem[rd_ptr_reg];
                    end
                end
                SEND: begin
                    if (ready) begin
                        if (launch) begin
                            mdata_reg <= mem[rd_ptr_reg];
                        end else begin
                            state_reg <= IDLE;
                            valid_reg <= 1'b0;
                            mdata_reg <= '0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    mdata_reg <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_count_reg <= '0;
        end else if (done) begin
            tx_count_reg <= tx_count_reg + 1'b1;
        end
    end

    assign valid     = valid_reg;
    assign mdata_out = mdata_reg;
    assign level     = level_reg;
    assign tx_count  = tx_count_reg;

endmodule
